// File: rtl/wb_grf.sv
// rtl/wb_grf.sv - writeback decode, 31-entry GPR file with write-through bypass, retire counter
// Optional sub-word loads (lb/lbu/lh/lhu) are enabled by defining WB_LOAD_EXT_EN.
module wb_grf #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_W,
  input  logic [31:0]      PC8_W,
  input  logic [31:0]      AO_W,
  input  logic [31:0]      DM_W,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic             WE_W,
  output logic [4:0]       A3_W,
  output logic [31:0]      WD_W,
  output logic [CNT_W-1:0] RETIRE_CNT
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
`ifdef WB_LOAD_EXT_EN
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
`endif

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        wr_cls;
  logic [4:0]  a3_raw;
  logic [31:0] wd_raw;

  assign op = IR_W[31:26];
  assign fn = IR_W[5:0];
  assign rt = IR_W[20:16];
  assign rd = IR_W[15:11];

`ifdef WB_LOAD_EXT_EN
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = DM_W[7:0];
    case (AO_W[1:0])
      2'd0:    byte_sel = DM_W[7:0];
      2'd1:    byte_sel = DM_W[15:8];
      2'd2:    byte_sel = DM_W[23:16];
      default: byte_sel = DM_W[31:24];
    endcase
  end

  // Halfword lane comes from AO_W[1] only; a misaligned AO_W[0] is ignored.
  assign half_sel = AO_W[1] ? DM_W[31:16] : DM_W[15:0];
`endif

  always_comb begin
    wr_cls = 1'b0;
    a3_raw = 5'd0;
    wd_raw = 32'd0;
    case (op)
      OP_SPECIAL: begin
        if (fn == FN_ADDU || fn == FN_SUBU) begin
          wr_cls = 1'b1;
          a3_raw = rd;
          wd_raw = AO_W;
        end
      end
      OP_ORI, OP_LUI: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = AO_W;
      end
      OP_LW: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = DM_W;
      end
      OP_JAL: begin
        wr_cls = 1'b1;
        a3_raw = 5'd31;
        wd_raw = PC8_W;
      end
`ifdef WB_LOAD_EXT_EN
      OP_LB: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = {{24{byte_sel[7]}}, byte_sel};
      end
      OP_LBU: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = {24'd0, byte_sel};
      end
      OP_LH: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = {{16{half_sel[15]}}, half_sel};
      end
      OP_LHU: begin
        wr_cls = 1'b1;
        a3_raw = rt;
        wd_raw = {16'd0, half_sel};
      end
`endif
      default: ;
    endcase
  end

  // Writes aimed at $0 are squashed so forwarding logic never sees them.
  assign WE_W = wr_cls && (a3_raw != 5'd0);
  assign A3_W = WE_W ? a3_raw : 5'd0;
  assign WD_W = WE_W ? wd_raw : 32'd0;

  logic [31:0] gpr_q [1:31];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) gpr_q[i] <= 32'd0;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (WE_W && A3_W == 5'(i)) gpr_q[i] <= WD_W;
      end
    end
  end

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 1; i < 32; i++) begin
      if (a == 5'(i)) v = gpr_q[i];
    end
    if (a != 5'd0 && WE_W && a == A3_W) v = WD_W;
    return v;
  endfunction

  assign RD1 = rd_port(A1);
  assign RD2 = rd_port(A2);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign cnt_d = (IR_W != 32'd0) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign RETIRE_CNT = cnt_q;

endmodule

// File: tb/tb_wb_grf.sv
// tb/tb_wb_grf.sv - directed self-checking bench for wb_grf (default and WB_LOAD_EXT_EN builds)
module tb_wb_grf;

  logic        clk;
  logic        reset;
  logic [31:0] IR_W, PC8_W, AO_W, DM_W;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2, WD_W;
  logic        WE_W;
  logic [4:0]  A3_W;
  logic [31:0] RETIRE_CNT;

  logic [31:0] RD1_4, RD2_4, WD_W_4;
  logic        WE_W_4;
  logic [4:0]  A3_W_4;
  logic [3:0]  RETIRE_CNT_4;

  int checks = 0;
  int errors = 0;

  wb_grf #(.CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W), .DM_W(DM_W),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .WE_W(WE_W), .A3_W(A3_W), .WD_W(WD_W),
    .RETIRE_CNT(RETIRE_CNT)
  );

  wb_grf #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .IR_W(IR_W), .PC8_W(PC8_W), .AO_W(AO_W), .DM_W(DM_W),
    .A1(A1), .A2(A2), .RD1(RD1_4), .RD2(RD2_4), .WE_W(WE_W_4), .A3_W(A3_W_4), .WD_W(WD_W_4),
    .RETIRE_CNT(RETIRE_CNT_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ir, input logic [31:0] ao);
    IR_W = ir;
    AO_W = ao;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    IR_W = 32'd0; PC8_W = 32'd0; AO_W = 32'd0; DM_W = 32'd0;
    A1 = 5'd5; A2 = 5'd7;
    tick(); tick();
    chk("reset_cnt", RETIRE_CNT, 32'd0);
    chk("reset_rd1", RD1, 32'd0);
    reset = 1'b1;
    #1;
    chk("nop_we", {31'd0, WE_W}, 32'd0);

    drive(32'h3405_1234, 32'h0000_1234);
    chk("ori_we", {31'd0, WE_W}, 32'd1);
    chk("ori_a3", {27'd0, A3_W}, 32'd5);
    chk("ori_wd", WD_W, 32'h0000_1234);
    tick();
    drive(32'h3407_BEEF, 32'hDEAD_BEEF);
    A1 = 5'd7; A2 = 5'd7;
    #1;
    chk("bypass_rd1", RD1, 32'hDEAD_BEEF);
    chk("bypass_rd2", RD2, 32'hDEAD_BEEF);
    tick();
    drive(32'd0, 32'd0);
    A1 = 5'd5; A2 = 5'd7;
    #1;
    chk("reg5", RD1, 32'h0000_1234);
    chk("reg7", RD2, 32'hDEAD_BEEF);
    tick();

    drive(32'h0022_0021, 32'd5);
    A1 = 5'd0;
    #1;
    chk("r0_we", {31'd0, WE_W}, 32'd0);
    chk("r0_a3", {27'd0, A3_W}, 32'd0);
    chk("r0_rd_bypass", RD1, 32'd0);
    tick();
    chk("r0_rd", RD1, 32'd0);

    PC8_W = 32'h0000_3008;
    drive(32'h0C00_0C02, 32'd0);
    chk("jal_a3", {27'd0, A3_W}, 32'd31);
    chk("jal_wd", WD_W, 32'h0000_3008);
    tick();
    drive(32'd0, 32'd0);
    A1 = 5'd31;
    #1;
    chk("reg31", RD1, 32'h0000_3008);
    tick();

    DM_W = 32'h80FF_7F01;
    drive(32'h8C09_0000, 32'h0000_0100);
    chk("lw_wd", WD_W, 32'h80FF_7F01);
    tick();
    drive(32'd0, 32'd0);
    A1 = 5'd9;
    #1;
    chk("reg9", RD1, 32'h80FF_7F01);
    drive(32'hAC0A_0000, 32'h0000_0010);
    chk("sw_we", {31'd0, WE_W}, 32'd0);
    tick();
    drive(32'hFC0A_0000, 32'h0000_0010);
    chk("undef_we", {31'd0, WE_W}, 32'd0);
    chk("undef_wd", WD_W, 32'd0);
    tick();
    chk("cnt7", RETIRE_CNT, 32'd7);

    drive(32'h0022_1821, 32'h0000_0011); tick();
    drive(32'd0, 32'd0);                 tick();
    drive(32'h0022_2023, 32'h0000_0022); tick();
    drive(32'd0, 32'd0);                 tick();
    drive(32'hAC0A_0000, 32'd0);         tick();
    chk("cnt_stream", RETIRE_CNT, 32'd10);
    drive(32'd0, 32'd0);
    A1 = 5'd3; A2 = 5'd4;
    #1;
    chk("reg3", RD1, 32'h0000_0011);
    chk("reg4", RD2, 32'h0000_0022);

    A1 = 5'd10; A2 = 5'd13;
`ifdef WB_LOAD_EXT_EN
    drive(32'h800A_0000, 32'h0000_0003);
    chk("lb_wd", WD_W, 32'hFFFF_FF80);
    tick();
    drive(32'h900B_0000, 32'h0000_0003);
    chk("lbu_wd", WD_W, 32'h0000_0080);
    tick();
    drive(32'h940C_0000, 32'h0000_0000);
    chk("lhu_wd", WD_W, 32'h0000_7F01);
    tick();
    drive(32'h840D_0000, 32'h0000_0003);
    chk("lh_wd", WD_W, 32'hFFFF_80FF);
    tick();
    drive(32'd0, 32'd0);
    chk("reg10", RD1, 32'hFFFF_FF80);
    chk("reg13", RD2, 32'hFFFF_80FF);
`else
    drive(32'h800A_0000, 32'h0000_0003);
    chk("lb_undef_we", {31'd0, WE_W}, 32'd0);
    tick();
    drive(32'h900B_0000, 32'h0000_0003); tick();
    drive(32'h940C_0000, 32'h0000_0000);
    chk("lhu_undef_we", {31'd0, WE_W}, 32'd0);
    tick();
    drive(32'h840D_0000, 32'h0000_0003); tick();
    drive(32'd0, 32'd0);
    chk("reg10", RD1, 32'd0);
    chk("reg13", RD2, 32'd0);
`endif
    chk("cnt14", RETIRE_CNT, 32'd14);

    drive(32'hFC00_0000, 32'd0); tick();
    drive(32'hFC00_0000, 32'd0); tick();
    drive(32'hFC00_0000, 32'd0); tick();
    drive(32'd0, 32'd0);
    chk("cnt17", RETIRE_CNT, 32'd17);
    chk("cnt4_wrap", {28'd0, RETIRE_CNT_4}, 32'd1);

    A1 = 5'd5; A2 = 5'd7;
    drive(32'h3405_5555, 32'h0000_5555);
    reset = 1'b0;
    #1;
    chk("arst_rd2", RD2, 32'd0);
    chk("arst_bypass", RD1, 32'h0000_5555);
    chk("arst_cnt", RETIRE_CNT, 32'd0);
    chk("arst_cnt4", {28'd0, RETIRE_CNT_4}, 32'd0);
    tick();
    A1 = 5'd31;
    #1;
    chk("arst_reg31", RD1, 32'd0);
    reset = 1'b1;
    A1 = 5'd5;
    #1;
    tick();
    drive(32'd0, 32'd0);
    chk("first_write", RD1, 32'h0000_5555);
    chk("first_cnt", RETIRE_CNT, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
